// File: rtl/vol_key_sequencer.sv
// vol_key_sequencer: debounced up/down volume keys with auto-repeat and a saturating 4-bit level
module vol_key_sequencer #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_RATE     = 5000000,
   parameter int LEVEL_INIT      = 8,
   parameter int LEVEL_MAX       = 15
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Vol_up,
   input  logic       Vol_down,
   output logic [3:0] vol_level,
   output logic       vol_inc,
   output logic       vol_dec,
   output logic       limit_hit,
   output logic       busy
);
   localparam int MAXP = (DEBOUNCE_CYCLES > REPEAT_DELAY)
                       ? ((DEBOUNCE_CYCLES > REPEAT_RATE) ? DEBOUNCE_CYCLES : REPEAT_RATE)
                       : ((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);
   localparam int CW = (MAXP > 2) ? $clog2(MAXP) : 1;
   localparam logic [CW-1:0] DB_END = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] RD_END = CW'(REPEAT_DELAY - 1);
   localparam logic [CW-1:0] RR_END = CW'(REPEAT_RATE - 1);
   localparam logic [3:0] LVL_MAX  = 4'(LEVEL_MAX);
   localparam logic [3:0] LVL_INIT = 4'(LEVEL_INIT);
   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] PRESS_DB = 3'd1;
   localparam logic [2:0] HOLD     = 3'd2;
   localparam logic [2:0] REPEAT   = 3'd3;
   localparam logic [2:0] REL_DB   = 3'd4;

   logic          up_s1_q, up_s_q, dn_s1_q, dn_s_q;
   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          dir_q, dir_d;
   logic [3:0]    level_q, level_d;
   logic          inc_q, inc_d, dec_q, dec_d, lim_q, lim_d, busy_q, busy_d;
   logic          held, step;

   // dir_q=1 means the latched key is Vol_down; held = latched key alone is pressed
   assign held = dir_q ? (up_s_q & ~dn_s_q) : (dn_s_q & ~up_s_q);

   // two-flop synchronizers, released (high) while in reset
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         up_s1_q <= 1'b1;
         up_s_q  <= 1'b1;
         dn_s1_q <= 1'b1;
         dn_s_q  <= 1'b1;
      end else begin
         up_s1_q <= Vol_up;
         up_s_q  <= up_s1_q;
         dn_s1_q <= Vol_down;
         dn_s_q  <= dn_s1_q;
      end
   end

   // key FSM with one shared counter, step decision and saturating level update
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      step    = 1'b0;
      case (state_q)
         IDLE:
            if (up_s_q ^ dn_s_q) begin
               state_d = PRESS_DB;
               dir_d   = up_s_q;
               cnt_d   = '0;
            end
         PRESS_DB:
            if (!held) state_d = IDLE;
            else if (cnt_q == DB_END) begin
               step    = 1'b1;
               state_d = HOLD;
               cnt_d   = '0;
            end else cnt_d = cnt_q + 1'b1;
         HOLD, REPEAT:
            if (!held) begin
               state_d = REL_DB;
               cnt_d   = '0;
            end else if (cnt_q == ((state_q == HOLD) ? RD_END : RR_END)) begin
               step    = 1'b1;
               state_d = REPEAT;
               cnt_d   = '0;
            end else cnt_d = cnt_q + 1'b1;
         REL_DB:
            if (!(up_s_q && dn_s_q)) cnt_d = '0;
            else if (cnt_q == DB_END) state_d = IDLE;
            else cnt_d = cnt_q + 1'b1;
         default: state_d = IDLE;
      endcase
      inc_d   = step && !dir_q && (level_q < LVL_MAX);
      dec_d   = step && dir_q && (level_q != 4'd0);
      lim_d   = step && !inc_d && !dec_d;
      level_d = inc_d ? level_q + 4'd1 : dec_d ? level_q - 4'd1 : level_q;
      busy_d  = state_d != IDLE;
   end

   // FSM state and registered outputs
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
         level_q <= LVL_INIT;
         inc_q   <= 1'b0;
         dec_q   <= 1'b0;
         lim_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         level_q <= level_d;
         inc_q   <= inc_d;
         dec_q   <= dec_d;
         lim_q   <= lim_d;
         busy_q  <= busy_d;
      end
   end

   assign vol_level = level_q;
   assign vol_inc   = inc_q;
   assign vol_dec   = dec_q;
   assign limit_hit = lim_q;
   assign busy      = busy_q;
endmodule

// File: tb/tb_vol_key_sequencer.sv
// tb_vol_key_sequencer: scenario tasks plus random key traffic against a run-length reference model
module tb_vol_key_sequencer;
   localparam int DB = 4;
   localparam int RD = 10;
   localparam int RR = 3;

   logic       Clk = 1'b0;
   logic       Reset = 1'b0;
   logic       Vol_up = 1'b1;
   logic       Vol_down = 1'b1;
   logic [3:0] vol_level;
   logic       vol_inc, vol_dec, limit_hit, busy;
   logic [7:0] dut_vec, exp_vec;
   int         checks = 0;
   int         failures = 0;

   int   m_mode, m_r, m_q, exp_lvl;
   bit   m_dir, u1, u2, d1, d2, mu, md, mheld, mstep;
   logic exp_inc, exp_dec, exp_lim, exp_busy;

   vol_key_sequencer #(
      .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .LEVEL_INIT(8), .LEVEL_MAX(15)
   ) dut (
      .Clk(Clk), .Reset(Reset), .Vol_up(Vol_up), .Vol_down(Vol_down),
      .vol_level(vol_level), .vol_inc(vol_inc), .vol_dec(vol_dec),
      .limit_hit(limit_hit), .busy(busy)
   );

   assign dut_vec = {vol_level, vol_inc, vol_dec, limit_hit, busy};

   always #5 Clk = ~Clk;

   // Reference model: mode 0 idle, 1 key held for m_r edges, 2 waiting for m_q quiet edges.
   // A step falls on held-run edge DB, DB+RD, then every RR edges.
   initial forever begin
      @(posedge Clk or negedge Reset);
      if (!Reset) begin
         m_mode = 0; m_r = 0; m_q = 0; m_dir = 0; exp_lvl = 8;
         u1 = 1; u2 = 1; d1 = 1; d2 = 1;
         exp_inc = 0; exp_dec = 0; exp_lim = 0; exp_busy = 0;
      end else begin
         mu = u2; md = d2; u2 = u1; d2 = d1; u1 = Vol_up; d1 = Vol_down;
         mstep = 0;
         if (m_mode == 0) begin
            if (mu != md) begin m_mode = 1; m_dir = mu; m_r = 0; end
         end else if (m_mode == 1) begin
            mheld = m_dir ? (!md && mu) : (!mu && md);
            if (!mheld) begin
               if (m_r < DB) m_mode = 0;
               else begin m_mode = 2; m_q = 0; end
            end else begin
               m_r++;
               mstep = (m_r == DB) || (m_r == DB + RD) || (m_r > DB + RD && (m_r - DB - RD) % RR == 0);
            end
         end else begin
            if (mu && md) begin
               m_q++;
               if (m_q == DB) m_mode = 0;
            end else m_q = 0;
         end
         exp_inc = mstep && !m_dir && exp_lvl < 15;
         exp_dec = mstep && m_dir && exp_lvl > 0;
         exp_lim = mstep && !exp_inc && !exp_dec;
         exp_lvl = exp_lvl + (exp_inc ? 1 : 0) - (exp_dec ? 1 : 0);
         exp_busy = m_mode != 0;
      end
      exp_vec = {exp_lvl[3:0], exp_inc, exp_dec, exp_lim, exp_busy};
   end

   task test_reset;
      Reset = 0; Vol_up = 1; Vol_down = 1;
      repeat (3) @(posedge Clk);
      #1;
      if (dut_vec !== 8'h80) begin failures++; $display("FAIL reset_state dut=%h exp=80", dut_vec); end
      checks++;
      Reset = 1;
      repeat (3) begin
         @(posedge Clk); #1;
         if (dut_vec !== exp_vec) begin failures++; $display("FAIL reset_idle dut=%h exp=%h", dut_vec, exp_vec); end
         checks++;
      end
   endtask

   task test_hold_repeat;
      for (int i = 0; i < 30; i++) begin
         Vol_up = (i < 20) ? 1'b0 : 1'b1;
         @(posedge Clk); #1;
         if (dut_vec !== exp_vec) begin failures++; $display("FAIL hold_model edge=%0d dut=%h exp=%h", i, dut_vec, exp_vec); end
         if (vol_inc !== (i == 6 || i == 16 || i == 19)) begin failures++; $display("FAIL hold_inc_time edge=%0d dut=%b", i, vol_inc); end
         if (busy !== (i >= 2 && i < 26)) begin failures++; $display("FAIL hold_busy_time edge=%0d dut=%b", i, busy); end
         checks += 3;
      end
      if (vol_level !== 4'd11) begin failures++; $display("FAIL hold_level dut=%0d exp=11", vol_level); end
      checks++;
   endtask

   task test_reset_mid_repeat;
      for (int i = 0; i < 18; i++) begin
         Vol_up = 0;
         @(posedge Clk); #1;
         if (dut_vec !== exp_vec) begin failures++; $display("FAIL midrst_model edge=%0d dut=%h exp=%h", i, dut_vec, exp_vec); end
         checks++;
      end
      #2 Reset = 0;
      #1;
      if (dut_vec !== 8'h80) begin failures++; $display("FAIL midrst_async dut=%h exp=80", dut_vec); end
      checks++;
      @(posedge Clk); #1;
      if (dut_vec !== 8'h80) begin failures++; $display("FAIL midrst_held dut=%h exp=80", dut_vec); end
      checks++;
      Vol_up = 1;
      @(posedge Clk); #1;
      Reset = 1;
      for (int i = 0; i < 8; i++) begin
         @(posedge Clk); #1;
         if (dut_vec !== 8'h80) begin failures++; $display("FAIL midrst_after edge=%0d dut=%h exp=80", i, dut_vec); end
         checks++;
      end
   endtask

   task test_glitch;
      for (int i = 0; i < 12; i++) begin
         Vol_down = (i < 3) ? 1'b0 : 1'b1;
         @(posedge Clk); #1;
         if (dut_vec !== exp_vec) begin failures++; $display("FAIL glitch_model edge=%0d dut=%h exp=%h", i, dut_vec, exp_vec); end
         if (vol_inc | vol_dec | limit_hit) begin failures++; $display("FAIL glitch_strobe edge=%0d dut=%b%b%b exp=000", i, vol_inc, vol_dec, limit_hit); end
         checks += 2;
      end
      if (vol_level !== 4'd8 || busy !== 1'b0) begin failures++; $display("FAIL glitch_end level=%0d busy=%b exp=8/0", vol_level, busy); end
      checks++;
   endtask

   task test_limits;
      int n_inc, n_dec, n_lim;
      for (int i = 0; i < 200 && exp_lvl != 14; i++) begin
         Vol_up = 0;
         @(posedge Clk); #1;
         if (dut_vec !== exp_vec) begin failures++; $display("FAIL lim_climb edge=%0d dut=%h exp=%h", i, dut_vec, exp_vec); end
         checks++;
      end
      Vol_up = 1;
      repeat (10) begin
         @(posedge Clk); #1;
         if (dut_vec !== exp_vec) begin failures++; $display("FAIL lim_rel dut=%h exp=%h", dut_vec, exp_vec); end
         checks++;
      end
      if (vol_level !== 4'd14) begin failures++; $display("FAIL lim_at14 dut=%0d exp=14", vol_level); end
      checks++;
      n_inc = 0; n_lim = 0;
      for (int i = 0; i < 40; i++) begin
         Vol_up = (i < 30) ? 1'b0 : 1'b1;
         @(posedge Clk); #1;
         n_inc += int'(vol_inc); n_lim += int'(limit_hit);
         if (dut_vec !== exp_vec) begin failures++; $display("FAIL lim_top edge=%0d dut=%h exp=%h", i, dut_vec, exp_vec); end
         checks++;
      end
      if (n_inc != 1 || n_lim < 2 || vol_level !== 4'd15) begin
         failures++; $display("FAIL lim_top_counts inc=%0d lim=%0d level=%0d exp=1/>=2/15", n_inc, n_lim, vol_level);
      end
      checks++;
      for (int i = 0; i < 80; i++) begin
         Vol_down = (i < 70) ? 1'b0 : 1'b1;
         @(posedge Clk); #1;
         if (dut_vec !== exp_vec) begin failures++; $display("FAIL lim_fall edge=%0d dut=%h exp=%h", i, dut_vec, exp_vec); end
         checks++;
      end
      n_dec = 0; n_lim = 0;
      for (int i = 0; i < 35; i++) begin
         Vol_down = (i < 25) ? 1'b0 : 1'b1;
         @(posedge Clk); #1;
         n_dec += int'(vol_dec); n_lim += int'(limit_hit);
         if (dut_vec !== exp_vec) begin failures++; $display("FAIL lim_bottom edge=%0d dut=%h exp=%h", i, dut_vec, exp_vec); end
         checks++;
      end
      if (n_dec != 0 || n_lim < 2 || vol_level !== 4'd0) begin
         failures++; $display("FAIL lim_bottom_counts dec=%0d lim=%0d level=%0d exp=0/>=2/0", n_dec, n_lim, vol_level);
      end
      checks++;
   endtask

   task test_conflict;
      int n_inc, n_dec;
      for (int i = 0; i < 19; i++) begin
         Vol_up = (i < 15) ? 1'b0 : 1'b1;
         Vol_down = Vol_up;
         @(posedge Clk); #1;
         if (dut_vec !== exp_vec) begin failures++; $display("FAIL both_model edge=%0d dut=%h exp=%h", i, dut_vec, exp_vec); end
         if (vol_inc | vol_dec | limit_hit | busy) begin failures++; $display("FAIL both_idle edge=%0d dut=%h", i, dut_vec); end
         checks += 2;
      end
      n_inc = 0; n_dec = 0;
      for (int i = 0; i < 40; i++) begin
         Vol_up = (i < 30) ? 1'b0 : 1'b1;
         Vol_down = (i >= 20 && i < 30) ? 1'b0 : 1'b1;
         @(posedge Clk); #1;
         n_inc += int'(vol_inc); n_dec += int'(vol_dec);
         if (dut_vec !== exp_vec) begin failures++; $display("FAIL abort_model edge=%0d dut=%h exp=%h", i, dut_vec, exp_vec); end
         checks++;
      end
      if (n_inc != 3 || n_dec != 0 || busy !== 1'b0) begin
         failures++; $display("FAIL abort_counts inc=%0d dec=%0d busy=%b exp=3/0/0", n_inc, n_dec, busy);
      end
      checks++;
      n_dec = 0;
      for (int i = 0; i < 20; i++) begin
         Vol_down = (i < 8) ? 1'b0 : 1'b1;
         @(posedge Clk); #1;
         n_dec += int'(vol_dec);
         if (dut_vec !== exp_vec) begin failures++; $display("FAIL fresh_model edge=%0d dut=%h exp=%h", i, dut_vec, exp_vec); end
         checks++;
      end
      if (n_dec != 1) begin failures++; $display("FAIL fresh_dec count=%0d exp=1", n_dec); end
      checks++;
   endtask

   task test_release_bounce;
      int n_inc;
      n_inc = 0;
      for (int i = 0; i < 28; i++) begin
         Vol_up = (i < 8) ? 1'b0 : ((i - 8) >= 12) || (((i - 8) / 2) % 2 == 0);
         @(posedge Clk); #1;
         n_inc += int'(vol_inc);
         if (dut_vec !== exp_vec) begin failures++; $display("FAIL bounce_model edge=%0d dut=%h exp=%h", i, dut_vec, exp_vec); end
         if (i == 24 && busy !== 1'b1) begin failures++; $display("FAIL bounce_busy_hold dut=%b exp=1", busy); end
         if (i == 25 && busy !== 1'b0) begin failures++; $display("FAIL bounce_idle dut=%b exp=0", busy); end
         checks += (i == 24 || i == 25) ? 2 : 1;
      end
      if (n_inc != 1) begin failures++; $display("FAIL bounce_incs count=%0d exp=1", n_inc); end
      checks++;
   endtask

   task test_random;
      int len, keys;
      for (int s = 0; s < 40; s++) begin
         len = $urandom_range(1, 40);
         keys = $urandom_range(0, 3);
         Vol_up = keys[0];
         Vol_down = keys[1];
         for (int i = 0; i < len; i++) begin
            @(posedge Clk); #1;
            if (dut_vec !== exp_vec) begin failures++; $display("FAIL rand_model seg=%0d edge=%0d dut=%h exp=%h", s, i, dut_vec, exp_vec); end
            if (int'(vol_inc) + int'(vol_dec) + int'(limit_hit) > 1) begin failures++; $display("FAIL rand_onehot seg=%0d dut=%b%b%b", s, vol_inc, vol_dec, limit_hit); end
            checks += 2;
         end
      end
   endtask

   initial begin
      test_reset;
      test_hold_repeat;
      test_reset_mid_repeat;
      test_glitch;
      test_limits;
      test_conflict;
      test_release_bounce;
      test_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
